// File: rtl/lcd_pkg.sv
// Shared definitions for the 4-bit character-LCD bus: receiver states,
// timing defaults (in clk cycles) used by the init/write FSMs and the
// receiver, and the command opcodes the receiver decodes.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        INIT2    = 3'd1,
        INIT3    = 3'd2,
        INIT4    = 3'd3,
        HI_NIB   = 3'd4,
        LO_NIB   = 3'd5
    } lcd_rx_state_t;

    localparam int T_POWERON_DEF = 750000;
    localparam int T_GAP1_DEF    = 205000;
    localparam int T_GAP2_DEF    = 5000;
    localparam int T_GAP3_DEF    = 2000;
    localparam int T_E_MIN_DEF   = 12;
    localparam int T_NIB_GAP_DEF = 50;
    localparam int T_CMD_GAP_DEF = 2000;
    localparam int T_CLR_GAP_DEF = 82000;

    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] HOME      = 8'h02;
    localparam logic [7:0] SET_DDRAM = 8'h80;

    // Nibble the display expects in each init state (8-bit, 8-bit, 8-bit, then 4-bit mode).
    function automatic logic [3:0] init_nibble(input lcd_rx_state_t s);
        return (s == INIT4) ? 4'h2 : 4'h3;
    endfunction

    // Clear (0x01) or return-home (0x02/0x03, bit 0 is don't-care) command.
    function automatic logic is_clear_home(input logic rs, input logic [7:0] b);
        return !rs && ((b == CLEAR) || ((b & 8'hFE) == HOME));
    endfunction

endpackage

// File: rtl/lcd_gap_timer.sv
// Saturating cycle counter with restart and a "count below required" compare.
// Latency: count is registered; o_short is combinational from the register.
// Backpressure: none; the count simply advances on i_inc and saturates.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_clr restarts the
//        count (at 1 when i_inc is also high); i_inc advances it; i_req is the
//        minimum acceptable count; o_short = count < i_req.
module lcd_gap_timer #(
    parameter int CNT_W = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_req,
    output logic             o_short
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    // Restarting at 1 when the restart cycle itself is counted makes the value
    // equal the number of qualifying cycles seen, edge cycle included.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? ONE : '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign o_short = (r_cnt < i_req);

endmodule

// File: rtl/lcd_nibble_rx.sv
// Display-side receiver for the 4-bit LCD bus: init tracking, byte assembly, timing/protocol checks.
// Latency: rx_valid/rx_data/init_done update one clk after E is first sampled low.
// Backpressure: none; the bus cannot be stalled, violations only raise sticky flags.
// Ports: clk, reset (async active-low); LCD_E/LCD_RS/LCD_RW/SF_D bus inputs;
//        rx_valid/rx_data/rx_rs byte output; init_done, timing_err, proto_err status.
// Optional: define LCD_RX_DDRAM_EN to add rx_addr[6:0], the mirrored DDRAM cursor.
module lcd_nibble_rx
    import lcd_pkg::*;
#(
    parameter int CNT_W     = 20,
    parameter int T_POWERON = T_POWERON_DEF,
    parameter int T_GAP1    = T_GAP1_DEF,
    parameter int T_GAP2    = T_GAP2_DEF,
    parameter int T_GAP3    = T_GAP3_DEF,
    parameter int T_E_MIN   = T_E_MIN_DEF,
    parameter int T_NIB_GAP = T_NIB_GAP_DEF,
    parameter int T_CMD_GAP = T_CMD_GAP_DEF,
    parameter int T_CLR_GAP = T_CLR_GAP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [3:0] SF_D,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_rs,
    output logic       init_done,
    output logic       timing_err,
`ifdef LCD_RX_DDRAM_EN
    output logic [6:0] rx_addr,
`endif
    output logic       proto_err
);

    lcd_rx_state_t    r_state;
    logic             r_e_q;
    logic [3:0]       r_d_q;
    logic             r_rs_q;
    logic             r_rw_q;
    logic [3:0]       r_hi;
    logic             r_hi_rs;
    logic             r_clr_prev;
    logic             r_rx_valid;
    logic [7:0]       r_rx_data;
    logic             r_rx_rs;
    logic             r_init_done;
    logic             r_timing_err;
    logic             r_proto_err;

    logic             w_rise;
    logic             w_fall;
    logic             w_rise_wr;
    logic             w_fall_wr;
    logic             w_width_short;
    logic             w_gap_short;
    logic             w_nib_ok;
    logic [7:0]       w_byte;
    logic [CNT_W-1:0] w_gap_req;

    assign w_rise    = LCD_E & ~r_e_q;
    assign w_fall    = r_e_q & ~LCD_E;
    // Read strobes are invisible to the protocol: RW at the rise gates the gap
    // check, RW of the last E-high cycle gates capture at the fall.
    assign w_rise_wr = w_rise & ~LCD_RW;
    assign w_fall_wr = w_fall & ~r_rw_q;
    assign w_nib_ok  = (r_d_q == init_nibble(r_state));
    assign w_byte    = {r_hi, r_d_q};

    always_comb begin
        w_gap_req = CNT_W'(T_CMD_GAP);
        case (r_state)
            PWR_WAIT: w_gap_req = CNT_W'(T_POWERON);
            INIT2:    w_gap_req = CNT_W'(T_GAP1);
            INIT3:    w_gap_req = CNT_W'(T_GAP2);
            INIT4:    w_gap_req = CNT_W'(T_GAP3);
            HI_NIB:   w_gap_req = r_clr_prev ? CNT_W'(T_CLR_GAP) : CNT_W'(T_CMD_GAP);
            LO_NIB:   w_gap_req = CNT_W'(T_NIB_GAP);
            default:  w_gap_req = CNT_W'(T_CMD_GAP);
        endcase
    end

    lcd_gap_timer #(.CNT_W(CNT_W)) u_width (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (w_rise),
        .i_inc   (LCD_E),
        .i_req   (CNT_W'(T_E_MIN)),
        .o_short (w_width_short)
    );

    // After reset E is low, so this counts from reset release in PWR_WAIT.
    lcd_gap_timer #(.CNT_W(CNT_W)) u_gap (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (w_fall_wr),
        .i_inc   (~LCD_E),
        .i_req   (w_gap_req),
        .o_short (w_gap_short)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= PWR_WAIT;
            r_e_q        <= 1'b0;
            r_d_q        <= 4'h0;
            r_rs_q       <= 1'b0;
            r_rw_q       <= 1'b0;
            r_hi         <= 4'h0;
            r_hi_rs      <= 1'b0;
            r_clr_prev   <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= 8'h00;
            r_rx_rs      <= 1'b0;
            r_init_done  <= 1'b0;
            r_timing_err <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_e_q      <= LCD_E;
            r_rx_valid <= 1'b0;
            // Sampled every E-high cycle so the fall sees the last-high-cycle values.
            if (LCD_E) begin
                r_d_q  <= SF_D;
                r_rs_q <= LCD_RS;
                r_rw_q <= LCD_RW;
            end
            if (w_rise_wr && w_gap_short) begin
                r_timing_err <= 1'b1;
            end
            if (w_fall_wr) begin
                if (w_width_short) begin
                    r_timing_err <= 1'b1;
                end
                case (r_state)
                    PWR_WAIT: if (w_nib_ok) r_state <= INIT2; else r_proto_err <= 1'b1;
                    INIT2:    if (w_nib_ok) r_state <= INIT3; else r_proto_err <= 1'b1;
                    INIT3:    if (w_nib_ok) r_state <= INIT4; else r_proto_err <= 1'b1;
                    INIT4: begin
                        if (w_nib_ok) begin
                            r_state     <= HI_NIB;
                            r_init_done <= 1'b1;
                        end else begin
                            r_proto_err <= 1'b1;
                        end
                    end
                    HI_NIB: begin
                        r_hi    <= r_d_q;
                        r_hi_rs <= r_rs_q;
                        r_state <= LO_NIB;
                    end
                    LO_NIB: begin
                        r_rx_data  <= w_byte;
                        r_rx_rs    <= r_hi_rs;
                        r_rx_valid <= 1'b1;
                        r_clr_prev <= is_clear_home(r_hi_rs, w_byte);
                        if (r_rs_q != r_hi_rs) begin
                            r_proto_err <= 1'b1;
                        end
                        r_state <= HI_NIB;
                    end
                    default: r_state <= PWR_WAIT;
                endcase
            end
        end
    end

`ifdef LCD_RX_DDRAM_EN
    logic [6:0] r_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= 7'h00;
        end else if (w_fall_wr && (r_state == LO_NIB)) begin
            if (r_hi_rs) begin
                r_addr <= r_addr + 7'd1;
            end else if ((w_byte & SET_DDRAM) != 8'h00) begin
                r_addr <= w_byte[6:0];
            end else if (is_clear_home(1'b0, w_byte)) begin
                r_addr <= 7'h00;
            end
        end
    end

    assign rx_addr = r_addr;
`endif

    assign rx_valid   = r_rx_valid;
    assign rx_data    = r_rx_data;
    assign rx_rs      = r_rx_rs;
    assign init_done  = r_init_done;
    assign timing_err = r_timing_err;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_lcd_nibble_rx.sv
// Bench for lcd_nibble_rx with timing budgets scaled down so that several
// full init sequences fit in a short run; a transaction-level model tracks
// the expected outputs from the bus rules.
module tb_lcd_nibble_rx;

    localparam int P_CNT_W   = 12;
    localparam int P_POWERON = 700;
    localparam int P_GAP1    = 205;
    localparam int P_GAP2    = 50;
    localparam int P_GAP3    = 20;
    localparam int P_E_MIN   = 12;
    localparam int P_NIB_GAP = 50;
    localparam int P_CMD_GAP = 200;
    localparam int P_CLR_GAP = 820;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       LCD_E  = 1'b0;
    logic       LCD_RS = 1'b0;
    logic       LCD_RW = 1'b0;
    logic [3:0] SF_D   = 4'h0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_rs;
    logic       init_done;
    logic       timing_err;
    logic       proto_err;
`ifdef LCD_RX_DDRAM_EN
    logic [6:0] rx_addr;
`endif

    always #5 clk = ~clk;

    lcd_nibble_rx #(
        .CNT_W(P_CNT_W), .T_POWERON(P_POWERON), .T_GAP1(P_GAP1), .T_GAP2(P_GAP2),
        .T_GAP3(P_GAP3), .T_E_MIN(P_E_MIN), .T_NIB_GAP(P_NIB_GAP),
        .T_CMD_GAP(P_CMD_GAP), .T_CLR_GAP(P_CLR_GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .LCD_E      (LCD_E),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .SF_D       (SF_D),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_rs      (rx_rs),
        .init_done  (init_done),
        .timing_err (timing_err),
`ifdef LCD_RX_DDRAM_EN
        .rx_addr    (rx_addr),
`endif
        .proto_err  (proto_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tb_low  = 0;   // E-low cycles since the last write strobe fell (or reset release)

    // Reference model: phase 0..3 = init nibble index, 4 = high nibble next, 5 = low nibble next.
    int         m_phase;
    logic       m_done, m_terr, m_perr, m_valid, m_rs, m_hirs, m_prevclr;
    logic [7:0] m_data;
    logic [3:0] m_hi;
    logic [6:0] m_addr;
    logic [3:0] init_seq [4];
    int         init_gap [4];

    typedef struct {
        logic [3:0] hi;
        logic [3:0] lo;
        logic       rs_hi;
        logic       rs_lo;
        int         gap_hi;
        logic [7:0] exp_data;
        logic       exp_rs;
        logic       exp_perr;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int req_now();
        if (m_phase < 4) return init_gap[m_phase];
        if (m_phase == 4) return m_prevclr ? P_CLR_GAP : P_CMD_GAP;
        return P_NIB_GAP;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_done = 0; m_terr = 0; m_perr = 0; m_valid = 0; m_rs = 0;
        m_hirs = 0; m_prevclr = 0; m_data = 8'h00; m_hi = 4'h0; m_addr = 7'h00;
    endtask

    task automatic model_fall(input logic [3:0] nib, input logic rs, input int w);
        if (w < P_E_MIN) m_terr = 1;
        if (m_phase < 4) begin
            if (nib == init_seq[m_phase]) begin
                m_phase++;
                if (m_phase == 4) m_done = 1;
            end else begin
                m_perr = 1;
            end
        end else if (m_phase == 4) begin
            m_hi = nib; m_hirs = rs; m_phase = 5;
        end else begin
            m_data = {m_hi, nib};
            m_rs = m_hirs;
            m_valid = 1;
            if (rs != m_hirs) m_perr = 1;
            m_prevclr = !m_hirs && (m_data >= 8'd1) && (m_data <= 8'd3);
            if (m_hirs) m_addr = m_addr + 7'd1;
            else if (m_data[7]) m_addr = m_data[6:0];
            else if (m_prevclr) m_addr = 7'h00;
            m_phase = 4;
        end
    endtask

    // One clock: the current drive values are what the next posedge samples.
    task automatic tick();
        if (!LCD_E && reset) tb_low++;
        @(negedge clk);
    endtask

    task automatic cmp_all(input string tag);
        check({tag, ".valid"}, 32'(rx_valid),   32'(m_valid));
        check({tag, ".data"},  32'(rx_data),    32'(m_data));
        check({tag, ".rs"},    32'(rx_rs),      32'(m_rs));
        check({tag, ".done"},  32'(init_done),  32'(m_done));
        check({tag, ".terr"},  32'(timing_err), 32'(m_terr));
        check({tag, ".perr"},  32'(proto_err),  32'(m_perr));
`ifdef LCD_RX_DDRAM_EN
        check({tag, ".addr"},  32'(rx_addr),    32'(m_addr));
`endif
    endtask

    // Strobe with 'gap' total E-low cycles before the rise and 'w' E-high cycles,
    // then compare everything one clk after the fall.
    task automatic send(input logic [3:0] nib, input logic rs, input logic rw,
                        input int w, input int gap, input string tag);
        while (tb_low < gap) tick();
        if (!rw && (tb_low < req_now())) m_terr = 1;
        LCD_E = 1'b1; SF_D = nib; LCD_RS = rs; LCD_RW = rw;
        repeat (w) tick();
        LCD_E = 1'b0; LCD_RW = 1'b0; SF_D = 4'($urandom); LCD_RS = 1'($urandom);
        m_valid = 0;
        if (!rw) begin
            tb_low = 0;
            model_fall(nib, rs, w);
        end
        tick();
        cmp_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0; LCD_E = 1'b0; LCD_RW = 1'b0;
        #1;
        check({tag, ".valid"}, 32'(rx_valid),   32'h0);
        check({tag, ".data"},  32'(rx_data),    32'h0);
        check({tag, ".rs"},    32'(rx_rs),      32'h0);
        check({tag, ".done"},  32'(init_done),  32'h0);
        check({tag, ".terr"},  32'(timing_err), 32'h0);
        check({tag, ".perr"},  32'(proto_err),  32'h0);
`ifdef LCD_RX_DDRAM_EN
        check({tag, ".addr"},  32'(rx_addr),    32'h0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tb_low = 0;
        model_reset();
    endtask

    task automatic do_init(input int gap1);
        send(4'h3, 1'b0, 1'b0, 12, P_POWERON, "init1");
        send(4'h3, 1'b0, 1'b0, 12, gap1,      "init2");
        send(4'h3, 1'b0, 1'b0, 12, P_GAP2,    "init3");
        send(4'h2, 1'b0, 1'b0, 12, P_GAP3,    "init4");
    endtask

    initial begin
        logic [7:0] b;
        logic       rs, rs_lo;
        int         g, w;

        init_seq = '{4'h3, 4'h3, 4'h3, 4'h2};
        init_gap = '{P_POWERON, P_GAP1, P_GAP2, P_GAP3};
        tbl[0] = '{4'h4, 4'h1, 1'b1, 1'b1, P_CMD_GAP, 8'h41, 1'b1, 1'b0};
        tbl[1] = '{4'h0, 4'h1, 1'b0, 1'b0, P_CMD_GAP, 8'h01, 1'b0, 1'b0};
        tbl[2] = '{4'h8, 4'h5, 1'b0, 1'b0, P_CLR_GAP, 8'h85, 1'b0, 1'b0};
        tbl[3] = '{4'h6, 4'h1, 1'b1, 1'b1, P_CMD_GAP, 8'h61, 1'b1, 1'b0};
        tbl[4] = '{4'h0, 4'h2, 1'b0, 1'b0, P_CMD_GAP, 8'h02, 1'b0, 1'b0};
        tbl[5] = '{4'h7, 4'hA, 1'b1, 1'b1, P_CLR_GAP, 8'h7A, 1'b1, 1'b0};
        tbl[6] = '{4'h0, 4'h3, 1'b0, 1'b0, P_CMD_GAP, 8'h03, 1'b0, 1'b0};
        tbl[7] = '{4'h3, 4'h3, 1'b1, 1'b0, P_CLR_GAP, 8'h33, 1'b1, 1'b1};
        model_reset();

        @(negedge clk);
        do_reset("rst0");

        // Nominal init at exactly the minimum gaps and width.
        do_init(P_GAP1);

        // Byte table at exactly the minimum gaps.
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].hi, tbl[i].rs_hi, 1'b0, 12, tbl[i].gap_hi, "tbl.hi");
            send(tbl[i].lo, tbl[i].rs_lo, 1'b0, 12, P_NIB_GAP,     "tbl.lo");
            check("tbl.valid", 32'(rx_valid),   32'h1);
            check("tbl.data",  32'(rx_data),    32'(tbl[i].exp_data));
            check("tbl.rs",    32'(rx_rs),      32'(tbl[i].exp_rs));
            check("tbl.perr",  32'(proto_err),  32'(tbl[i].exp_perr));
            check("tbl.terr",  32'(timing_err), 32'h0);
            tick();
            check("tbl.vdrop", 32'(rx_valid),   32'h0);
        end

        // 11-cycle E pulse: sticky timing error, bytes keep flowing.
        send(4'h5, 1'b1, 1'b0, 11, P_CMD_GAP, "narrow.hi");
        check("narrow.terr", 32'(timing_err), 32'h1);
        send(4'h2, 1'b1, 1'b0, 12, P_NIB_GAP, "narrow.lo");
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            send(b[7:4], 1'b1, 1'b0, 12, P_CMD_GAP, "after.hi");
            send(b[3:0], 1'b1, 1'b0, 12, P_NIB_GAP, "after.lo");
            check("after.data",   32'(rx_data),    32'(b));
            check("after.sticky", 32'(timing_err), 32'h1);
        end

        // Second init gap one cycle short, then exact.
        do_reset("rst1");
        do_init(P_GAP1 - 1);
        check("gap1.short", 32'(timing_err), 32'h1);
        do_reset("rst2");
        do_init(P_GAP1);
        check("gap1.exact", 32'(timing_err), 32'h0);

        // Clear followed by a rise one cycle early.
        send(4'h0, 1'b0, 1'b0, 12, P_CMD_GAP, "clr.hi");
        send(4'h1, 1'b0, 1'b0, 12, P_NIB_GAP, "clr.lo");
        send(4'h8, 1'b0, 1'b0, 12, P_CLR_GAP - 1, "clr.early");
        check("clr.terr", 32'(timing_err), 32'h1);

        // Wrong first init nibble: state held, next 0x3 advances.
        do_reset("rst3");
        send(4'h2, 1'b0, 1'b0, 12, P_POWERON, "bad.first");
        check("bad.perr", 32'(proto_err), 32'h1);
        send(4'h3, 1'b0, 1'b0, 12, P_POWERON, "bad.adv");
        send(4'h3, 1'b0, 1'b0, 12, P_GAP1,    "bad.i3");
        send(4'h3, 1'b0, 1'b0, 12, P_GAP2,    "bad.i4");
        send(4'h2, 1'b0, 1'b0, 12, P_GAP3,    "bad.i5");
        check("bad.done", 32'(init_done), 32'h1);

        // Reset after a lone high nibble, then a strobe far too early.
        do_reset("rst4");
        do_init(P_GAP1);
        send(4'h4, 1'b1, 1'b0, 12, P_CMD_GAP, "lone.hi");
        do_reset("rst5");
        send(4'h3, 1'b0, 1'b0, 12, 100, "early");
        check("early.terr", 32'(timing_err), 32'h1);
        send(4'h3, 1'b0, 1'b0, 12, P_GAP1, "early.i2");
        send(4'h3, 1'b0, 1'b0, 12, P_GAP2, "early.i3");
        send(4'h2, 1'b0, 1'b0, 12, P_GAP3, "early.i4");
        send(4'h6, 1'b1, 1'b0, 12, P_CMD_GAP, "fresh.hi");
        send(4'h9, 1'b1, 1'b0, 12, P_NIB_GAP, "fresh.lo");

        // Randomised traffic with occasional violations and read strobes.
        do_reset("rst6");
        do_init(P_GAP1);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom_range(1, 3)); rs = 1'b0;
            end else begin
                b = 8'($urandom); rs = 1'($urandom);
            end
            if ($urandom_range(0, 7) == 0)
                send(4'($urandom), 1'($urandom), 1'b1, int'($urandom_range(1, 14)),
                     tb_low + int'($urandom_range(1, 4)), "rnd.rw");
            g = req_now() + int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) g = req_now() - 1;
            w = ($urandom_range(0, 9) == 0) ? 11 : 12 + int'($urandom_range(0, 2));
            send(b[7:4], rs, 1'b0, w, g, "rnd.hi");
            rs_lo = ($urandom_range(0, 9) == 0) ? ~rs : rs;
            g = req_now() + int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) g = req_now() - 1;
            send(b[3:0], rs_lo, 1'b0, 12, g, "rnd.lo");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
